// File: rtl/asip_pipe_pkg.sv
// Shared types and constants for the vector ASIP pipeline registers.
package asip_pipe_pkg;

  localparam int unsigned DATA_W = 128;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned CTRL_W = 8;

  // extnd_sel encodings: which source registers an instruction actually reads
  localparam logic [1:0] EXT_RRR = 2'b00;
  localparam logic [1:0] EXT_RRI = 2'b01;
  localparam logic [1:0] EXT_RI  = 2'b10;
  localparam logic [1:0] EXT_I   = 2'b11;

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } stage_state_e;

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] rd2;
    logic [DATA_W-1:0] rd3;
    logic [ADDR_W-1:0] r2;
    logic [ADDR_W-1:0] r3;
    logic [ADDR_W-1:0] dest;
    logic [1:0]        extnd_sel;
    logic              vf;
    logic [CTRL_W-1:0] ctrl;
    logic              mem_read;
    logic              reg_write;
  } id_ex_t;

  localparam id_ex_t ID_EX_BUBBLE = '0;

  function automatic logic r2_used(input logic [1:0] sel);
    return ~sel[1];
  endfunction

  function automatic logic r3_used(input logic [1:0] sel);
    return (sel == EXT_RRR);
  endfunction

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard check between the EX-stage load and the decode instruction.
module load_use_detect #(
  parameter int unsigned ADDR_W = 4
) (
  input  logic              ex_valid_i,
  input  logic              ex_mem_read_i,
  input  logic              ex_reg_write_i,
  input  logic              ex_vf_i,
  input  logic [ADDR_W-1:0] ex_dest_i,
  input  logic              id_valid_i,
  input  logic              id_vf_i,
  input  logic [1:0]        id_extnd_sel_i,
  input  logic [ADDR_W-1:0] id_r2_i,
  input  logic [ADDR_W-1:0] id_r3_i,
  output logic              hazard_o
);
  import asip_pipe_pkg::*;

  logic ex_is_load;
  logic src_match;

  assign ex_is_load = ex_valid_i & ex_mem_read_i & ex_reg_write_i & (ex_dest_i != '0);
  assign src_match  = (r2_used(id_extnd_sel_i) & (id_r2_i == ex_dest_i)) |
                      (r3_used(id_extnd_sel_i) & (id_r3_i == ex_dest_i));
  assign hazard_o   = ex_is_load & id_valid_i & (ex_vf_i == id_vf_i) & src_match;

endmodule

// File: rtl/id_ex_stage.sv
// Decode->execute pipeline register with load-use bubble insertion.
// Optional stall/bubble counters: define ID_EX_STALL_STATS_EN.
module id_ex_stage #(
  parameter int unsigned DATA_W   = asip_pipe_pkg::DATA_W,
  parameter int unsigned ADDR_W   = asip_pipe_pkg::ADDR_W,
  parameter int unsigned CTRL_W   = asip_pipe_pkg::CTRL_W,
  parameter int unsigned LOAD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic              ext_stall_i,
  input  logic              id_valid_i,
  input  logic [DATA_W-1:0] id_rd2_i,
  input  logic [DATA_W-1:0] id_rd3_i,
  input  logic [ADDR_W-1:0] id_r2_i,
  input  logic [ADDR_W-1:0] id_r3_i,
  input  logic [ADDR_W-1:0] id_dest_i,
  input  logic [1:0]        id_extnd_sel_i,
  input  logic              id_vf_i,
  input  logic [CTRL_W-1:0] id_ctrl_i,
  input  logic              id_mem_read_i,
  input  logic              id_reg_write_i,
  output logic              ex_valid_o,
  output logic [DATA_W-1:0] ex_rd2_o,
  output logic [DATA_W-1:0] ex_rd3_o,
  output logic [ADDR_W-1:0] ex_r2_o,
  output logic [ADDR_W-1:0] ex_r3_o,
  output logic [ADDR_W-1:0] ex_dest_o,
  output logic [1:0]        ex_extnd_sel_o,
  output logic              ex_vf_o,
  output logic [CTRL_W-1:0] ex_ctrl_o,
  output logic              ex_mem_read_o,
  output logic              ex_reg_write_o,
  output logic              id_stall_o
`ifdef ID_EX_STALL_STATS_EN
  ,
  output logic [31:0]       stall_cnt_o,
  output logic [31:0]       bubble_cnt_o
`endif
);
  import asip_pipe_pkg::*;

  localparam logic [2:0] LAT_M1 = 3'(LOAD_LAT - 1);

  id_ex_t       ex_q, ex_d, id_fields;
  stage_state_e state_q, state_d;
  logic [2:0]   cnt_q, cnt_d;
  logic         hazard;
  logic         bubble;

  assign id_fields = '{valid:     id_valid_i,
                       rd2:       id_rd2_i,
                       rd3:       id_rd3_i,
                       r2:        id_r2_i,
                       r3:        id_r3_i,
                       dest:      id_dest_i,
                       extnd_sel: id_extnd_sel_i,
                       vf:        id_vf_i,
                       ctrl:      id_ctrl_i,
                       mem_read:  id_mem_read_i,
                       reg_write: id_reg_write_i};

  load_use_detect #(.ADDR_W(ADDR_W)) u_load_use_detect (
    .ex_valid_i     (ex_q.valid),
    .ex_mem_read_i  (ex_q.mem_read),
    .ex_reg_write_i (ex_q.reg_write),
    .ex_vf_i        (ex_q.vf),
    .ex_dest_i      (ex_q.dest),
    .id_valid_i     (id_valid_i),
    .id_vf_i        (id_vf_i),
    .id_extnd_sel_i (id_extnd_sel_i),
    .id_r2_i        (id_r2_i),
    .id_r3_i        (id_r3_i),
    .hazard_o       (hazard)
  );

  always_comb begin
    ex_d    = ex_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    bubble  = 1'b0;
    if (flush_i) begin
      ex_d    = ID_EX_BUBBLE;
      state_d = RUN;
      cnt_d   = '0;
      bubble  = 1'b1;
    end else if (ext_stall_i) begin
      // everything holds
    end else if (state_q == HOLD) begin
      ex_d   = ID_EX_BUBBLE;
      bubble = 1'b1;
      cnt_d  = cnt_q - 3'd1;
      if (cnt_q == 3'd1) state_d = RUN;
    end else if (hazard) begin
      ex_d    = ID_EX_BUBBLE;
      bubble  = 1'b1;
      cnt_d   = LAT_M1;
      state_d = (LOAD_LAT > 1) ? HOLD : RUN;
    end else begin
      ex_d = id_fields;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q    <= ID_EX_BUBBLE;
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      ex_q    <= ex_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign id_stall_o = ext_stall_i |
                      (~flush_i & (((state_q == RUN) & hazard) | (state_q == HOLD)));

  assign ex_valid_o     = ex_q.valid;
  assign ex_rd2_o       = ex_q.rd2;
  assign ex_rd3_o       = ex_q.rd3;
  assign ex_r2_o        = ex_q.r2;
  assign ex_r3_o        = ex_q.r3;
  assign ex_dest_o      = ex_q.dest;
  assign ex_extnd_sel_o = ex_q.extnd_sel;
  assign ex_vf_o        = ex_q.vf;
  assign ex_ctrl_o      = ex_q.ctrl;
  assign ex_mem_read_o  = ex_q.mem_read;
  assign ex_reg_write_o = ex_q.reg_write;

`ifdef ID_EX_STALL_STATS_EN
  logic [31:0] stall_cnt_q, bubble_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      if (id_stall_o & ~ext_stall_i & ~&stall_cnt_q) stall_cnt_q  <= stall_cnt_q + 32'd1;
      if (bubble & ~&bubble_cnt_q)                   bubble_cnt_q <= bubble_cnt_q + 32'd1;
    end
  end

  assign stall_cnt_o  = stall_cnt_q;
  assign bubble_cnt_o = bubble_cnt_q;
`else
  logic unused_bubble;
  assign unused_bubble = bubble;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: LOAD_LAT=1 and LOAD_LAT=3 instances share one stimulus stream.
module tb_id_ex_stage;
  logic         clk, rst_n, flush_i, ext_stall_i;
  logic         id_valid_i, id_vf_i, id_mem_read_i, id_reg_write_i;
  logic [127:0] id_rd2_i, id_rd3_i;
  logic [3:0]   id_r2_i, id_r3_i, id_dest_i;
  logic [1:0]   id_extnd_sel_i;
  logic [7:0]   id_ctrl_i;

  logic         o1_valid, o1_vf, o1_mr, o1_rw, o1_stall;
  logic [127:0] o1_rd2, o1_rd3;
  logic [3:0]   o1_r2, o1_r3, o1_dest;
  logic [1:0]   o1_ext;
  logic [7:0]   o1_ctrl;
  logic         o3_valid, o3_vf, o3_mr, o3_rw, o3_stall;
  logic [127:0] o3_rd2, o3_rd3;
  logic [3:0]   o3_r2, o3_r3, o3_dest;
  logic [1:0]   o3_ext;
  logic [7:0]   o3_ctrl;

  int checks = 0;
  int errors = 0;

  id_ex_stage #(.LOAD_LAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i), .ext_stall_i(ext_stall_i),
    .id_valid_i(id_valid_i), .id_rd2_i(id_rd2_i), .id_rd3_i(id_rd3_i),
    .id_r2_i(id_r2_i), .id_r3_i(id_r3_i), .id_dest_i(id_dest_i),
    .id_extnd_sel_i(id_extnd_sel_i), .id_vf_i(id_vf_i), .id_ctrl_i(id_ctrl_i),
    .id_mem_read_i(id_mem_read_i), .id_reg_write_i(id_reg_write_i),
    .ex_valid_o(o1_valid), .ex_rd2_o(o1_rd2), .ex_rd3_o(o1_rd3),
    .ex_r2_o(o1_r2), .ex_r3_o(o1_r3), .ex_dest_o(o1_dest),
    .ex_extnd_sel_o(o1_ext), .ex_vf_o(o1_vf), .ex_ctrl_o(o1_ctrl),
    .ex_mem_read_o(o1_mr), .ex_reg_write_o(o1_rw), .id_stall_o(o1_stall)
`ifdef ID_EX_STALL_STATS_EN
    , .stall_cnt_o(), .bubble_cnt_o()
`endif
  );

  id_ex_stage #(.LOAD_LAT(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i), .ext_stall_i(ext_stall_i),
    .id_valid_i(id_valid_i), .id_rd2_i(id_rd2_i), .id_rd3_i(id_rd3_i),
    .id_r2_i(id_r2_i), .id_r3_i(id_r3_i), .id_dest_i(id_dest_i),
    .id_extnd_sel_i(id_extnd_sel_i), .id_vf_i(id_vf_i), .id_ctrl_i(id_ctrl_i),
    .id_mem_read_i(id_mem_read_i), .id_reg_write_i(id_reg_write_i),
    .ex_valid_o(o3_valid), .ex_rd2_o(o3_rd2), .ex_rd3_o(o3_rd3),
    .ex_r2_o(o3_r2), .ex_r3_o(o3_r3), .ex_dest_o(o3_dest),
    .ex_extnd_sel_o(o3_ext), .ex_vf_o(o3_vf), .ex_ctrl_o(o3_ctrl),
    .ex_mem_read_o(o3_mr), .ex_reg_write_o(o3_rw), .id_stall_o(o3_stall)
`ifdef ID_EX_STALL_STATS_EN
    , .stall_cnt_o(), .bubble_cnt_o()
`endif
  );

`ifdef ID_EX_STALL_STATS_EN
  logic         o2_valid, o2_vf, o2_mr, o2_rw, o2_stall;
  logic [127:0] o2_rd2, o2_rd3;
  logic [3:0]   o2_r2, o2_r3, o2_dest;
  logic [1:0]   o2_ext;
  logic [7:0]   o2_ctrl;
  logic [31:0]  o2_stall_cnt, o2_bubble_cnt;

  id_ex_stage #(.LOAD_LAT(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i), .ext_stall_i(ext_stall_i),
    .id_valid_i(id_valid_i), .id_rd2_i(id_rd2_i), .id_rd3_i(id_rd3_i),
    .id_r2_i(id_r2_i), .id_r3_i(id_r3_i), .id_dest_i(id_dest_i),
    .id_extnd_sel_i(id_extnd_sel_i), .id_vf_i(id_vf_i), .id_ctrl_i(id_ctrl_i),
    .id_mem_read_i(id_mem_read_i), .id_reg_write_i(id_reg_write_i),
    .ex_valid_o(o2_valid), .ex_rd2_o(o2_rd2), .ex_rd3_o(o2_rd3),
    .ex_r2_o(o2_r2), .ex_r3_o(o2_r3), .ex_dest_o(o2_dest),
    .ex_extnd_sel_o(o2_ext), .ex_vf_o(o2_vf), .ex_ctrl_o(o2_ctrl),
    .ex_mem_read_o(o2_mr), .ex_reg_write_o(o2_rw), .id_stall_o(o2_stall),
    .stall_cnt_o(o2_stall_cnt), .bubble_cnt_o(o2_bubble_cnt)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic v, input logic [3:0] r2, input logic [3:0] r3,
                           input logic [3:0] dest, input logic [1:0] ext, input logic vf,
                           input logic mr, input logic rw, input logic [7:0] ctrl,
                           input logic [127:0] rd2);
    id_valid_i = v; id_r2_i = r2; id_r3_i = r3; id_dest_i = dest;
    id_extnd_sel_i = ext; id_vf_i = vf; id_mem_read_i = mr; id_reg_write_i = rw;
    id_ctrl_i = ctrl; id_rd2_i = rd2; id_rd3_i = ~rd2;
  endtask

  task automatic idle();
    set_instr(0, 0, 0, 0, 2'b00, 0, 0, 0, 8'h00, '0);
  endtask

  // load to vector r5, and its R2 consumer writing r6
  task automatic load_v5();
    set_instr(1, 4'd1, 4'd2, 4'd5, 2'b00, 1, 1, 1, 8'hA5, 128'h1234_5678_9ABC_DEF0);
  endtask

  task automatic consumer();
    set_instr(1, 4'd5, 4'd0, 4'd6, 2'b00, 1, 0, 1, 8'h3C, 128'hC0DE);
  endtask

  initial begin
    rst_n = 1'b0; flush_i = 1'b0; ext_stall_i = 1'b0;
    idle();
    tick();
    check("rst1 valid", o1_valid, 0); check("rst1 rd2", o1_rd2, 0);
    check("rst1 rd3", o1_rd3, 0);     check("rst1 r2", o1_r2, 0);
    check("rst1 r3", o1_r3, 0);       check("rst1 dest", o1_dest, 0);
    check("rst1 ext", o1_ext, 0);     check("rst1 vf", o1_vf, 0);
    check("rst1 ctrl", o1_ctrl, 0);   check("rst1 mr", o1_mr, 0);
    check("rst1 rw", o1_rw, 0);
    check("rst3 all", |{o3_valid, o3_rd2, o3_rd3, o3_r2, o3_r3, o3_dest, o3_ext,
                        o3_vf, o3_ctrl, o3_mr, o3_rw}, 0);
`ifdef ID_EX_STALL_STATS_EN
    check("rst2 all", |{o2_valid, o2_rd2, o2_rd3, o2_r2, o2_r3, o2_dest, o2_ext,
                        o2_vf, o2_ctrl, o2_mr, o2_rw}, 0);
`endif
    ext_stall_i = 1'b1; #1;
    check("rst stall follows ext 1", o1_stall, 1);
    ext_stall_i = 1'b0; #1;
    check("rst stall follows ext 0", o3_stall, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // basic load-use hazard
    load_v5(); #1;
    check("A load no stall", o1_stall, 0);
    tick();
    check("A ex load rd2", o1_rd2, 128'h1234_5678_9ABC_DEF0);
    check("A ex load mr", o3_mr, 1);
    check("A ex load dest", o3_dest, 5);
    consumer(); #1;
    check("A hazard stall1", o1_stall, 1);
    check("A hazard stall3", o3_stall, 1);
    tick();
    check("A bubble1 valid", o1_valid, 0);
    check("A bubble3 valid", o3_valid, 0);
    check("A stall1 done", o1_stall, 0);
    check("A hold3 stall c2", o3_stall, 1);
    tick();
    check("A dut1 consumer valid", o1_valid, 1);
    check("A dut1 consumer dest", o1_dest, 6);
    check("A dut1 consumer ctrl", o1_ctrl, 8'h3C);
    check("A dut3 bubble2", o3_valid, 0);
    check("A hold3 stall c3", o3_stall, 1);
    tick();
    check("A dut3 bubble3", o3_valid, 0);
    check("A dut3 stall released", o3_stall, 0);
    tick();
    check("A dut3 consumer valid", o3_valid, 1);
    check("A dut3 consumer rd2", o3_rd2, 128'hC0DE);
    idle(); tick();

    // ext_stall during HOLD freezes the counter
    load_v5(); tick();
    consumer(); tick();
    ext_stall_i = 1'b1; #1;
    check("B ext stall1", o1_stall, 1);
    tick(); tick();
    check("B frozen bubble3", o3_valid, 0);
    ext_stall_i = 1'b0; #1;
    check("B still hold3", o3_stall, 1);
    check("B dut1 run", o1_stall, 0);
    tick();
    check("B hold3 after release", o3_stall, 1);
    check("B dut3 bubble", o3_valid, 0);
    tick();
    check("B dut3 back to run", o3_stall, 0);
    tick();
    check("B dut3 consumer", o3_dest, 6);
    set_instr(1, 4'd0, 4'd0, 4'd9, 2'b11, 0, 0, 1, 8'h77, 128'h99);
    ext_stall_i = 1'b1;
    tick();
    check("B ext freeze dest", o3_dest, 6);
    check("B ext freeze ctrl", o3_ctrl, 8'h3C);
    ext_stall_i = 1'b0;
    tick();
    check("B new instr dest", o3_dest, 9);
    idle(); tick();

    // cases forwarding covers or that read no matching source
    set_instr(1, 4'd1, 4'd2, 4'd5, 2'b00, 0, 1, 1, 8'hA5, '0); tick();
    set_instr(1, 4'd5, 4'd0, 4'd6, 2'b00, 1, 0, 1, 8'h3C, '0); #1;
    check("N1 vf mismatch", o3_stall, 0);
    idle(); tick();
    set_instr(1, 4'd1, 4'd2, 4'd0, 2'b00, 1, 1, 1, 8'hA5, '0); tick();
    set_instr(1, 4'd0, 4'd0, 4'd6, 2'b00, 1, 0, 1, 8'h3C, '0); #1;
    check("N2 reg0 load", o3_stall, 0);
    idle(); tick();
    load_v5(); tick();
    set_instr(1, 4'd1, 4'd5, 4'd6, 2'b01, 1, 0, 1, 8'h3C, '0); #1;
    check("N3 r3 unused ext01", o3_stall, 0);
    idle(); tick();
    load_v5(); tick();
    set_instr(1, 4'd5, 4'd0, 4'd6, 2'b10, 1, 0, 1, 8'h3C, '0); #1;
    check("N4 r2 unused ext10", o1_stall, 0);
    idle(); tick();

    // R3 hazard, squashed by flush
    load_v5(); tick();
    set_instr(1, 4'd1, 4'd5, 4'd6, 2'b00, 1, 0, 1, 8'h3C, '0); #1;
    check("P5 r3 hazard", o3_stall, 1);
    flush_i = 1'b1; #1;
    check("P5 flush stall3", o3_stall, 0);
    check("P5 flush stall1", o1_stall, 0);
    tick();
    flush_i = 1'b0; #1;
    check("P5 flush bubble valid", o3_valid, 0);
    check("P5 flush bubble rw", o3_rw, 0);
    check("P5 flush bubble dest", o3_dest, 0);
    check("P5 flush bubble ctrl", o3_ctrl, 0);
    check("P5 state run after flush", o3_stall, 0);
    idle(); tick();

    // async reset mid-HOLD
    load_v5(); tick();
    consumer(); tick(); tick();
    check("R dut1 holds consumer", o1_valid, 1);
    check("R dut3 in hold", o3_stall, 1);
    #2 rst_n = 1'b0; #1;
    check("R async valid", o1_valid, 0);
    check("R async rd2", o1_rd2, 0);
    check("R async dest", o1_dest, 0);
    check("R hold abandoned", o3_stall, 0);
    idle(); tick();
    rst_n = 1'b1;
    tick();

`ifdef ID_EX_STALL_STATS_EN
    load_v5(); tick();
    consumer(); tick(); tick();
    load_v5(); tick();
    consumer(); tick(); tick();
    idle(); tick(); tick();
    check("S stall_cnt", o2_stall_cnt, 4);
    check("S bubble_cnt", o2_bubble_cnt, 4);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
